// File: rtl/dsp_regfile_sequencer.sv
// Front-end sequencer for a 64x32 dual-port register file: buffers write-backs
// in an in-order queue, drains up to two per cycle, and holds off hazarded reads.
module dsp_regfile_sequencer #(
  parameter int QDEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [5:0]  rd_ra,
  input  logic [5:0]  rd_rb,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [31:0] rd_qa,
  output logic [31:0] rd_qb,
  input  logic        wr_req,
  input  logic [5:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic        ram_nwea,
  output logic        ram_nweb,
  output logic        ram_clka,
  output logic        ram_clkb,
  output logic [5:0]  ram_aa,
  output logic [5:0]  ram_ab,
  output logic [31:0] ram_da,
  output logic [31:0] ram_db,
  input  logic [31:0] ram_qa,
  input  logic [31:0] ram_qb
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_READ,
    CYC_WRITE
  } cyc_t;

  logic [5:0]    addr_q [QDEPTH];
  logic [31:0]   data_q [QDEPTH];
  logic [PW-1:0] head_reg;
  logic [CW-1:0] count_reg;
  logic          rd_valid_reg;

  logic [PW-1:0]     second_idx;
  logic [PW-1:0]     tail_idx;
  logic [5:0]        head_addr;
  logic [5:0]        second_addr;
  logic [31:0]       head_data;
  logic [31:0]       second_data;
  logic [QDEPTH-1:0] slot_match;
  logic              full;
  logic              hazard;
  logic              pair_ok;
  logic              push;
  logic [1:0]        pop_cnt;
  cyc_t              cyc;

  assign second_idx  = head_reg + PW'(1);
  assign tail_idx    = head_reg + count_reg[PW-1:0];
  assign head_addr   = addr_q[head_reg];
  assign head_data   = data_q[head_reg];
  assign second_addr = addr_q[second_idx];
  assign second_data = data_q[second_idx];

  assign full    = (count_reg == CW'(QDEPTH));
  assign pair_ok = (count_reg >= CW'(2)) && (second_addr != head_addr);
  assign push    = wr_req & ~full & ~reset;
  assign wr_ack  = push;

  // Hazard looks only at entries already registered; this cycle's push is excluded.
  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_match
      logic [PW-1:0] slot;
      assign slot = head_reg + PW'(gi);
      assign slot_match[gi] = (CW'(gi) < count_reg) &&
                              ((addr_q[slot] == rd_ra) || (addr_q[slot] == rd_rb));
    end
  endgenerate

  assign hazard = rd_req & (|slot_match);

  always_comb begin
    cyc = CYC_IDLE;
    if ((count_reg != '0) && (!rd_req || hazard || full)) begin
      cyc = CYC_WRITE;
    end else if (rd_req) begin
      cyc = CYC_READ;
    end
  end

  always_comb begin
    ram_nwea = 1'b1;
    ram_nweb = 1'b1;
    ram_clka = 1'b0;
    ram_clkb = 1'b0;
    ram_aa   = '0;
    ram_ab   = '0;
    ram_da   = '0;
    ram_db   = '0;
    rd_ack   = 1'b0;
    pop_cnt  = 2'd0;
    if (!reset) begin
      case (cyc)
        CYC_WRITE: begin
          ram_nwea = 1'b0;
          ram_clka = 1'b1;
          ram_aa   = head_addr;
          ram_da   = head_data;
          pop_cnt  = 2'd1;
          // Same-address pairs split so the younger write lands last.
          if (pair_ok) begin
            ram_nweb = 1'b0;
            ram_clkb = 1'b1;
            ram_ab   = second_addr;
            ram_db   = second_data;
            pop_cnt  = 2'd2;
          end
        end
        CYC_READ: begin
          ram_aa = rd_ra;
          ram_ab = rd_rb;
          rd_ack = 1'b1;
        end
        default: begin
          ram_aa = rd_ra;
          ram_ab = rd_rb;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      head_reg     <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      head_reg     <= head_reg + PW'(pop_cnt);
      count_reg    <= count_reg + CW'(push) - CW'(pop_cnt);
      rd_valid_reg <= rd_ack;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      addr_q[tail_idx] <= wr_addr;
      data_q[tail_idx] <= wr_data;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_qa    = ram_qa;
  assign rd_qb    = ram_qb;

endmodule

// File: tb/tb_dsp_regfile_sequencer.sv
// Randomized bench for dsp_regfile_sequencer: a queue-based reference of the
// pending write-backs plus a shadow register file predicts every output each cycle.
module tb_dsp_regfile_sequencer;

  localparam int QDEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_ra = '0;
  logic [5:0]  rd_rb = '0;
  logic        rd_ack;
  logic        rd_valid;
  logic [31:0] rd_qa;
  logic [31:0] rd_qb;
  logic        wr_req = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic        ram_nwea, ram_nweb, ram_clka, ram_clkb;
  logic [5:0]  ram_aa, ram_ab;
  logic [31:0] ram_da, ram_db;
  logic [31:0] ram_qa = '0;
  logic [31:0] ram_qb = '0;

  always #5 sys_clk = ~sys_clk;

  dsp_regfile_sequencer #(.QDEPTH(QDEPTH)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .rd_req(rd_req), .rd_ra(rd_ra), .rd_rb(rd_rb),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_qa(rd_qa), .rd_qb(rd_qb),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_nwea(ram_nwea), .ram_nweb(ram_nweb), .ram_clka(ram_clka), .ram_clkb(ram_clkb),
    .ram_aa(ram_aa), .ram_ab(ram_ab), .ram_da(ram_da), .ram_db(ram_db),
    .ram_qa(ram_qa), .ram_qb(ram_qb)
  );

  // Dual-port RAM with registered read (read-before-write).
  logic [31:0] ram [64] = '{default: '0};
  always @(posedge sys_clk) begin
    if (ram_clka && !ram_nwea) ram[ram_aa] <= ram_da;
    if (ram_clkb && !ram_nweb) ram[ram_ab] <= ram_db;
    ram_qa <= ram[ram_aa];
    ram_qb <= ram[ram_ab];
  end

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] ref_mem [64];
  bit          exp_valid;
  logic [31:0] exp_qa, exp_qb;
  logic [5:0]  exp_ra, exp_rb;
  bit          last_wr_ack;
  int          vec_count = 0;
  int          err_count = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architecturally current value: youngest queued write, else the committed copy.
  function automatic logic [31:0] latest(input logic [5:0] a);
    logic [31:0] v;
    v = ref_mem[a];
    foreach (mq[i]) if (mq[i].addr == a) v = mq[i].data;
    return v;
  endfunction

  task automatic eval_cycle();
    int pend;
    bit full, hz, wr_cyc, two, racc, wacc;
    pend = mq.size();
    full = (pend == QDEPTH);
    if (reset) begin
      check_val("rst_rd_ack", 32'(rd_ack), 32'd0);
      check_val("rst_wr_ack", 32'(wr_ack), 32'd0);
      check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_val("rst_nwe", {30'd0, ram_nwea, ram_nweb}, 32'd3);
      check_val("rst_clk", {30'd0, ram_clka, ram_clkb}, 32'd0);
      check_val("rst_addr", {20'd0, ram_aa, ram_ab}, 32'd0);
      check_val("rst_da", ram_da, 32'd0);
      check_val("rst_db", ram_db, 32'd0);
      mq.delete();
      exp_valid = 0;
      last_wr_ack = 0;
      return;
    end
    hz = 0;
    foreach (mq[i]) if (mq[i].addr == rd_ra || mq[i].addr == rd_rb) hz = 1;
    hz = hz && rd_req;
    wr_cyc = (pend > 0) && (!rd_req || hz || full);
    racc = rd_req && !wr_cyc;
    wacc = wr_req && !full;
    two = wr_cyc && (pend >= 2) && (mq[1].addr != mq[0].addr);

    check_val("rd_ack", 32'(rd_ack), 32'(racc));
    check_val("wr_ack", 32'(wr_ack), 32'(wacc));
    check_val("port_a_we", {30'd0, ram_nwea, ram_clka}, wr_cyc ? 32'd1 : 32'd2);
    check_val("port_b_we", {30'd0, ram_nweb, ram_clkb}, two ? 32'd1 : 32'd2);
    if (wr_cyc) begin
      check_val("wr_a_addr", 32'(ram_aa), 32'(mq[0].addr));
      check_val("wr_a_data", ram_da, mq[0].data);
      if (two) begin
        check_val("wr_b_addr", 32'(ram_ab), 32'(mq[1].addr));
        check_val("wr_b_data", ram_db, mq[1].data);
      end
    end else begin
      check_val("rd_addrs", {20'd0, ram_aa, ram_ab}, {20'd0, rd_ra, rd_rb});
    end
    check_val("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_val("rd_qa", rd_qa, exp_qa);
      check_val("rd_qb", rd_qb, exp_qb);
      $display("read r%0d=%h r%0d=%h", exp_ra, rd_qa, exp_rb, rd_qb);
    end

    last_wr_ack = wr_ack;
    exp_valid = racc;
    if (racc) begin
      exp_ra = rd_ra;
      exp_rb = rd_rb;
      exp_qa = latest(rd_ra);
      exp_qb = latest(rd_rb);
    end
    if (wr_cyc) begin
      ref_mem[mq[0].addr] = mq[0].data;
      void'(mq.pop_front());
      if (two) begin
        ref_mem[mq[0].addr] = mq[0].data;
        void'(mq.pop_front());
      end
    end
    if (wacc) mq.push_back('{addr: wr_addr, data: wr_data});
  endtask

  task automatic step();
    @(negedge sys_clk);
    eval_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cyc(input bit rq, input logic [5:0] ra, input logic [5:0] rb,
                     input bit wq, input logic [5:0] wa, input logic [31:0] wd, input int n);
    rd_req = rq; rd_ra = ra; rd_rb = rb;
    wr_req = wq; wr_addr = wa; wr_data = wd;
    for (int k = 0; k < n; k++) step();
  endtask

  // Hold a write-back until accepted, bounded.
  task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
    bit done;
    done = 0;
    wr_req = 1; wr_addr = a; wr_data = d;
    for (int k = 0; k < 16 && !done; k++) begin
      step();
      done = last_wr_ack;
    end
    if (!done) check_val("wr_timeout", 32'd0, 32'd1);
    wr_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    exp_valid = 0;
    last_wr_ack = 0;
    cyc(0, 0, 0, 0, 0, 0, 2);
    reset = 0;
    step();

    // Basic write then read
    cyc(0, 0, 0, 1, 5, 32'h12345678, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 5, 6, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 2);

    // Hazard: read of r7 held while r7 is queued
    cyc(1, 7, 8, 1, 7, 32'hDEADBEEF, 1);
    cyc(1, 7, 8, 0, 0, 0, 3);
    cyc(0, 0, 0, 0, 0, 0, 2);

    // Full queue with non-hazard reads held
    rd_req = 1; rd_ra = 1; rd_rb = 2;
    for (int i = 0; i < 5; i++) push_wr(6'(10 + i), 32'hA000_0000 + 32'(i));
    cyc(0, 0, 0, 0, 0, 0, 4);
    cyc(1, 10, 14, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 2);

    // Same-address pair
    rd_req = 0;
    push_wr(3, 32'd1);
    push_wr(3, 32'd2);
    cyc(0, 0, 0, 0, 0, 0, 3);
    cyc(1, 3, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 2);

    // Simultaneous write-back and read of the same register
    push_wr(9, 32'h55);
    cyc(0, 0, 0, 0, 0, 0, 2);
    cyc(1, 9, 9, 1, 9, 32'hAA, 1);
    cyc(0, 0, 0, 0, 0, 0, 2);
    cyc(1, 9, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 2);

    // Reset mid-stream with three entries queued
    rd_req = 1; rd_ra = 20; rd_rb = 21;
    push_wr(30, 32'h30);
    push_wr(31, 32'h31);
    push_wr(32, 32'h32);
    wr_req = 1; wr_addr = 33; wr_data = 32'h33;
    reset = 1;
    step();
    reset = 0;
    cyc(0, 0, 0, 0, 0, 0, 2);
    cyc(1, 30, 31, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 2);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      rd_req  = ($urandom_range(0, 99) < 60);
      rd_ra   = 6'($urandom_range(0, 7));
      rd_rb   = 6'($urandom_range(0, 7));
      wr_req  = ($urandom_range(0, 99) < 50);
      wr_addr = 6'($urandom_range(0, 7));
      wr_data = $urandom;
      reset   = ($urandom_range(0, 299) == 0);
      step();
      reset = 0;
    end
    cyc(0, 0, 0, 0, 0, 0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/dsp_regfile_sequencer.md
# dsp_regfile_sequencer

Front-end controller for the DSP's 64x32 dual-port register file. It owns both RAM ports and arbitrates between operand reads from the decode stage and result write-backs from the execute/load stages. Write-backs are buffered in a small in-order queue and drained one or two per cycle. Reads that would hit a still-queued write are held off, so every read returns architecturally current data.

## Interface
Parameters:
- QDEPTH, 4, write-back queue entries (power of two, 2..8)

Ports:
- sys_clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  operand read request
- rd_ra  in  6  operand A register index
- rd_rb  in  6  operand B register index
- rd_ack  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_qa/rd_qb valid this cycle
- rd_qa  out  32  operand A data
- rd_qb  out  32  operand B data
- wr_req  in  1  write-back request
- wr_addr  in  6  write-back register index
- wr_data  in  32  write-back data
- wr_ack  out  1  write-back accepted this cycle (combinational)
- ram_nwea / ram_nweb  out  1  RAM port A/B write enable, active low
- ram_clka / ram_clkb  out  1  RAM port A/B enable; high only on write cycles
- ram_aa / ram_ab  out  6  RAM port A/B address
- ram_da / ram_db  out  32  RAM port A/B write data
- ram_qa / ram_qb  in  32  RAM port A/B read data (registered in RAM, 1-cycle latency)

## Operation
- The queue is a FIFO of {addr, data} entries with registered count 0..QDEPTH. full = (count==QDEPTH).
- wr_ack = wr_req & ~full & ~reset. The decision uses the registered count. A push and a pop in the same cycle are allowed.
- hazard = rd_req and (rd_ra or rd_rb) matches the addr of any valid registered queue entry. An entry pushed in the current cycle is not considered.
- Each cycle is exactly one of three types, decided combinationally:
  - WRITE when count>0 and (~rd_req | hazard | full).
  - READ when rd_req and the cycle is not WRITE.
  - IDLE otherwise.
- WRITE cycle:
  - Head entry goes to port A: ram_nwea=0, ram_clka=1, ram_aa/ram_da = head.
  - If count>=2 and entry1.addr != head.addr, entry1 also goes to port B (ram_nweb=0, ram_clkb=1) and two entries pop.
  - Otherwise only the head pops, and port B is inactive (ram_nweb=1, ram_clkb=0).
  - rd_ack=0.
- READ cycle: ram_aa=rd_ra, ram_ab=rd_rb, both write enables high, both clk enables low, rd_ack=1.
- IDLE cycle: as READ for addresses, rd_ack=0, no writes.
- Ordering: a read accepted in the same cycle as a write-back to the same register returns the old value. The read is ordered before that write.
- rd_valid is a register: set to rd_ack of the previous cycle. rd_qa=ram_qa and rd_qb=ram_qb pass straight through.
- Starvation bound: a hazarded read is accepted at most ceil(count/1) WRITE cycles later, provided the write-back source stops hitting that register.
- Reset (asynchronous, any time):
  - Queue emptied and count=0; queued entries are discarded.
  - rd_valid=0.
  - ram_nwea=ram_nweb=1, ram_clka=ram_clkb=0, ram_aa=ram_ab=0, ram_da=ram_db=0.
  - rd_ack=wr_ack=0 while reset is high.
  - An in-flight rd_valid is cancelled.

## Timing
- Write accepted in cycle N: entry is visible in the queue at N+1 and written to the RAM at the end of N+1 at the earliest. A read of that register is accepted at N+2 or later, with data at N+3.
- Read accepted in cycle N: RAM addresses are driven in N and rd_valid/data are presented in N+1.
- Throughput:
  - 1 read per cycle when the queue is empty and no write-backs arrive.
  - Up to 2 queue pops per WRITE cycle.
  - Sustained 1 write-back per cycle with reads interleaved whenever the queue is non-full.
- RAM write-enable and address outputs are combinational from registered queue state plus rd_req/rd_ra/rd_rb. There is no path from ram_qa/ram_qb to any control output.

## Test plan
- Reset: assert reset mid-stream with 3 entries queued. Required response: all outputs at the reset values above, count=0, no RAM write in the following cycle, rd_valid=0.
- Basic: write r5=0x12345678 with rd_req low, then read ra=5, rb=6. Required response: ram_nwea=0 one cycle after wr_ack, rd_ack two cycles later, rd_qa=0x12345678 on the rd_valid cycle.
- Hazard: queue r7=0xDEADBEEF while holding rd_req with ra=7. Required response: rd_ack=0 during the drain cycle, rd_ack=1 on the next cycle, rd_qa=0xDEADBEEF one cycle later.
- Full: hold rd_req (ra=1, rb=2, non-hazard) and push 5 write-backs to r10..r14. Required response: wr_ack=0 on the 5th push when count=4, a forced WRITE cycle with r10 on port A and r11 on port B, then the 5th push accepted.
- Same-address pair: queue r3=1 then r3=2 and let them drain. Required response: two separate single-port WRITE cycles, and a read of r3 returns 2.
- Simultaneous: in the same cycle, wr_req to r9=0xAA and an accepted read of r9 (previously 0x55). Required response: the read returns 0x55, and a later read returns 0xAA.
